led_pio_arbiter: RTL and testbench

Round-robin arbiter and write sequencer that shares the 8-bit LED PIO output port among up to four requesters. It grants one requester at a time and issues a single zero-wait-state Avalon-MM write of that requester's byte to PIO register 0. It then holds off further writes for a programmable number of cycles so that each LED pattern stays visible. The block sits between the software-visible and hardware status sources and the LED PIO slave, and acts as that slave's only master.

---
 rtl/led_pio_arbiter.sv | 156 +++++++++++++++
 tb/tb_led_pio_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pio_arbiter.sv
// Round-robin arbiter that shares the LED PIO among NUM_REQ requesters, one Avalon write per grant.
// Latency: req sampled at edge k -> write strobe/ack visible k+1..k+2; then HOLD_CYCLES idle cycles.
// Backpressure: requesters hold req until ack; req is ignored while busy. Macro: LED_ARB_PRIO0_EN.
module led_pio_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [1:0]                grant_id,
  output logic                      busy,
  output logic                      pio_chipselect,
  output logic                      pio_write_n,
  output logic [1:0]                pio_address,
  output logic [31:0]               pio_writedata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic [DATA_W-1:0]    cap_q, cap_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 cs_q, cs_d;
  logic                 wr_n_q, wr_n_d;
  logic [31:0]          wdata_q, wdata_d;

  // Requests and bytes padded to four slots so a 2-bit index is always legal.
  logic [3:0]           req4;
  logic [DATA_W-1:0]    data_a [4];
  logic                 win_vld;
  logic [1:0]           win_idx;
  logic [2:0]           cand;
  logic [3:0]           ack4;

  for (genvar g = 0; g < 4; g++) begin : g_pad
    if (g < NUM_REQ) begin : g_used
      assign req4[g]   = req[g];
      assign data_a[g] = req_data[g*DATA_W +: DATA_W];
    end else begin : g_unused
      assign req4[g]   = 1'b0;
      assign data_a[g] = '0;
    end
  end

  // Winner search: first requester after the last grant, wrapping at NUM_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    cand    = 3'd0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = {1'b0, grant_q} + 3'(off);
      if (cand >= 3'(NUM_REQ)) begin
        cand = cand - 3'(NUM_REQ);
      end
      if (!win_vld && req4[cand[1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[1:0];
      end
    end
`ifdef LED_ARB_PRIO0_EN
    // Requester 0 overrides the pointer; with req[0] low the search above
    // naturally covers only requesters 1..NUM_REQ-1.
    if (req4[0]) begin
      win_vld = 1'b1;
      win_idx = 2'd0;
    end
`endif
  end

  assign ack4 = 4'b0001 << grant_q;

  // Next state and next registered outputs; bus strobes default to inactive.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    cs_d    = 1'b0;
    wr_n_d  = 1'b1;
    wdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          grant_d = win_idx;
          cap_d   = data_a[win_idx];
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cs_d                  = 1'b1;
        wr_n_d                = 1'b0;
        wdata_d[DATA_W-1:0]   = cap_q;
        ack_d                 = ack4[NUM_REQ-1:0];
        cnt_d                 = CNT_W'(HOLD_CYCLES - 1);
        state_d               = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset points the pointer at the last requester
  // so requester 0 is searched first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= 2'(NUM_REQ - 1);
      cap_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b0;
      wr_n_q  <= 1'b1;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
      wr_n_q  <= wr_n_d;
      wdata_q <= wdata_d;
    end
  end

  assign ack            = ack_q;
  assign grant_id       = grant_q;
  assign busy           = busy_q;
  assign pio_chipselect = cs_q;
  assign pio_write_n    = wr_n_q;
  assign pio_address    = 2'b00;
  assign pio_writedata  = wdata_q;

endmodule

// File: tb/tb_led_pio_arbiter.sv
// Bench for led_pio_arbiter: vector table, hand-written corner sequences and
// randomized requesters checked against a transaction-level timing model.
module tb_led_pio_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int HOLD    = 4;
  localparam int CNT_W   = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy, pio_chipselect, pio_write_n;
  logic [1:0]  pio_address;
  logic [31:0] pio_writedata;

  int checks = 0;
  int errors = 0;

  led_pio_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .ack(ack),
    .grant_id(grant_id), .busy(busy), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_address(pio_address), .pio_writedata(pio_writedata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    req_data = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " ack"}, 32'(ack), 32'h0);
    check({tag, " grant_id"}, 32'(grant_id), 32'd3);
    check({tag, " busy"}, 32'(busy), 32'h0);
    check({tag, " chipselect"}, 32'(pio_chipselect), 32'h0);
    check({tag, " write_n"}, 32'(pio_write_n), 32'h1);
    check({tag, " address"}, 32'(pio_address), 32'h0);
    check({tag, " writedata"}, pio_writedata, 32'h0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check({tag, " idle reached"}, 32'(busy), 32'h0);
  endtask

  task automatic wait_write(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!pio_chipselect && n < limit);
  endtask

  // Reference winner: first requester after pointer p, wrapping over four.
  function automatic int pick(input int p, input logic [3:0] r);
    int res;
    res = -1;
`ifdef LED_ARB_PRIO0_EN
    if (r[0]) res = 0;
`endif
    for (int off = 1; off <= 4; off++) begin
      if (res < 0 && ((r >> ((p + off) % 4)) & 4'd1) != 4'd0) res = (p + off) % 4;
    end
    return res;
  endfunction

  typedef struct {
    logic [3:0]  rq;
    logic [31:0] dat;
    logic [1:0]  exp_id;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int n, nw, bcnt;
    int wt[8];
    logic [31:0] wd[8];
    logic [3:0]  wa[8];
    int ptr, free_at, wr_at, wr_idx, g_at, grant_m, w;
    logic [7:0] wr_dat;
    logic wr;

    // Pointer sequence starts at 0 (after the single-request test).
    tbl[0] = '{4'b0010, 32'h00000F00, 2'd1, 8'h0F};
    tbl[1] = '{4'b1000, 32'hF0000000, 2'd3, 8'hF0};
    tbl[2] = '{4'b0101, 32'h44332211, 2'd0, 8'h11};
    tbl[3] = '{4'b0101, 32'h44332211, 2'd2, 8'h33};
    tbl[4] = '{4'b1010, 32'hA1B2C3D4, 2'd3, 8'hA1};
    tbl[5] = '{4'b0111, 32'h0E0D0C0B, 2'd0, 8'h0B};
    tbl[6] = '{4'b1110, 32'h5F6E7D8C, 2'd1, 8'h7D};
    tbl[7] = '{4'b1100, 32'h12345678, 2'd2, 8'h34};
    tbl[8] = '{4'b0011, 32'h9ABCDEF0, 2'd0, 8'hF0};

    // Reset values while reset is held.
    reset_n = 1'b0;
    tick();
    check_reset_vals("reset");
    do_reset();

    // Single request: write contents and busy duration.
    req = 4'b0001;
    req_data = 32'h000000A5;
    bcnt = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (busy) bcnt++;
      if (pio_chipselect) begin
        check("single latency", 32'(t), 32'd2);
        check("single write_n", 32'(pio_write_n), 32'h0);
        check("single address", 32'(pio_address), 32'h0);
        check("single writedata", pio_writedata, 32'h000000A5);
        check("single ack", 32'(ack), 32'h1);
        check("single grant_id", 32'(grant_id), 32'h0);
        req = '0;
      end
    end
    check("single busy cycles", 32'(bcnt), 32'd5);

    // Table of one-shot requests walking the round-robin pointer.
    for (int i = 0; i < 9; i++) begin
      wait_idle("table");
      req = tbl[i].rq;
      req_data = tbl[i].dat;
      wait_write(10, n);
      check($sformatf("table%0d latency", i), 32'(n), 32'd2);
      check($sformatf("table%0d write_n", i), 32'(pio_write_n), 32'h0);
      check($sformatf("table%0d writedata", i), pio_writedata, {24'h0, tbl[i].exp_byte});
      check($sformatf("table%0d ack", i), 32'(ack), 32'(4'b0001 << tbl[i].exp_id));
      check($sformatf("table%0d grant_id", i), 32'(grant_id), 32'(tbl[i].exp_id));
      req = '0;
    end

    // Full contention from reset: 0x11,0x22,0x33,0x44,0x11 every 6 cycles.
    do_reset();
    req = 4'b1111;
    req_data = 32'h44332211;
    nw = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (pio_chipselect && nw < 8) begin
        wt[nw] = t;
        wd[nw] = pio_writedata;
        wa[nw] = ack;
        nw++;
      end
    end
    req = '0;
    check("contention write count", 32'(nw >= 5), 32'h1);
    for (int k = 0; k < 5 && k < nw; k++) begin
      check($sformatf("contention w%0d data", k), wd[k], 32'((k % 4 + 1) * 8'h11));
      check($sformatf("contention w%0d ack", k), 32'(wa[k]), 32'(4'b0001 << (k % 4)));
      if (k > 0) check($sformatf("contention w%0d spacing", k), 32'(wt[k] - wt[k-1]), 32'd6);
    end
    wait_idle("contention");

    // Late data change during WRITE must not reach the bus.
    req = 4'b0100;
    req_data = 32'h005A0000;
    tick();
    req_data = 32'h00FF0000;
    tick();
    check("late data chipselect", 32'(pio_chipselect), 32'h1);
    check("late data writedata", pio_writedata, 32'h0000005A);
    req = '0;
    wait_idle("late data");

    // Reset two cycles into HOLD drops everything and restarts the pointer.
    req = 4'b0010;
    req_data = 32'h00002200;
    tick();
    tick();
    check("midhold write seen", pio_writedata, 32'h00000022);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check_reset_vals("midhold");
    tick();
    req = 4'b1111;
    req_data = 32'h44332211;
    reset_n = 1'b1;
    wait_write(10, n);
    check("post-reset latency", 32'(n), 32'd2);
    check("post-reset writedata", pio_writedata, 32'h00000011);
    check("post-reset ack", 32'(ack), 32'h1);
    check("post-reset grant_id", 32'(grant_id), 32'h0);
    req = '0;

`ifdef LED_ARB_PRIO0_EN
    // Requester 0 dominates; dropping it lets requester 2 in at the next IDLE.
    do_reset();
    req = 4'b0101;
    req_data = 32'h00CC00AA;
    nw = 0;
    for (int t = 1; t <= 40 && nw < 4; t++) begin
      tick();
      if (pio_chipselect) begin
        wt[nw] = t;
        wd[nw] = pio_writedata;
        wa[nw] = ack;
        nw++;
        if (nw == 3) req = 4'b0100;
      end
    end
    req = '0;
    check("prio0 write count", 32'(nw), 32'd4);
    for (int k = 0; k < 3 && k < nw; k++) begin
      check($sformatf("prio0 w%0d data", k), wd[k], 32'h000000AA);
      check($sformatf("prio0 w%0d ack", k), 32'(wa[k]), 32'h1);
    end
    if (nw == 4) begin
      check("prio0 drop data", wd[3], 32'h000000CC);
      check("prio0 drop ack", 32'(wa[3]), 32'h4);
      check("prio0 drop spacing", 32'(wt[3] - wt[2]), 32'd6);
    end
    wait_idle("prio0");
`endif

    // Randomized requesters against the transaction-level model.
    do_reset();
    ptr = 3; grant_m = 3; free_at = 0; wr_at = -10; wr_idx = 0; g_at = -100; wr_dat = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc >= free_at && req != 4'b0) begin
        w = pick(ptr, req);
        ptr = w; grant_m = w; g_at = cyc; wr_at = cyc + 1; wr_idx = w;
        wr_dat = 8'(req_data >> (8 * w));
        free_at = cyc + HOLD + 2;
      end
      tick();
      wr = (cyc == wr_at);
      check("rand chipselect", 32'(pio_chipselect), 32'(wr));
      check("rand write_n", 32'(pio_write_n), 32'(!wr));
      check("rand writedata", pio_writedata, wr ? {24'h0, wr_dat} : 32'h0);
      check("rand ack", 32'(ack), wr ? 32'(4'b0001 << wr_idx) : 32'h0);
      check("rand grant_id", 32'(grant_id), 32'(grant_m));
      check("rand busy", 32'(busy), 32'(cyc >= g_at && cyc <= g_at + HOLD));
      for (int i = 0; i < 4; i++) begin
        logic [3:0] m;
        m = 4'(1 << i);
        if (wr && i == wr_idx) begin
          req = req & ~m;
        end else if ((req & m) == 4'b0) begin
          if ($urandom_range(0, 5) == 0) begin
            req = req | m;
            req_data = (req_data & ~(32'hFF << (8 * i))) | (32'($urandom_range(0, 255)) << (8 * i));
          end
        end else if ($urandom_range(0, 4) == 0) begin
          req_data = (req_data & ~(32'hFF << (8 * i))) | (32'($urandom_range(0, 255)) << (8 * i));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
